// File: rtl/loadable_down_counter_5bit_if.sv
// Control/status bundle for the loadable down counter.
// The master side drives load/start/en and the preset; the slave side reports count and flags.
interface loadable_down_counter_5bit_if #(
  parameter int WIDTH = 5
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             start;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             zero;
  logic             tc;

  modport master (
    output load, data_in, start, en,
    input  count, busy, zero, tc
  );

  modport slave (
    input  load, data_in, start, en,
    output count, busy, zero, tc
  );
endinterface

// File: rtl/loadable_down_counter_5bit.sv
// Loadable 5-bit down counter / one-shot timer with a registered terminal-count pulse.
// Optional periodic mode: define DOWN_COUNTER_AUTO_RELOAD_EN to reload from the shadow at terminal.
module loadable_down_counter_5bit #(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] MIN_COUNT = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  loadable_down_counter_5bit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TERM_STEP = MIN_COUNT + ONE;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] shadow_reg, shadow_next;
  logic             tc_reg, tc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= MIN_COUNT;
      shadow_reg <= '0;
      tc_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      shadow_reg <= shadow_next;
      tc_reg     <= tc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    shadow_next = shadow_reg;
    tc_next     = 1'b0;

    if (bus.load) begin
      // A load while running restarts from the new value without leaving RUN.
      count_next  = bus.data_in;
      shadow_next = bus.data_in;
      state_next  = (state_reg == RUN) ? RUN : ARMED;
    end else begin
      case (state_reg)
        ARMED: begin
          if (bus.start) state_next = RUN;
        end
        RUN: begin
          if (count_reg == MIN_COUNT) begin
            // Zero preset: finish without decrementing so the count cannot wrap.
            tc_next    = 1'b1;
            state_next = DONE;
          end else if (bus.en) begin
            if (count_reg == TERM_STEP) begin
              tc_next = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
              if (shadow_reg != '0) begin
                count_next = shadow_reg;
              end else begin
                count_next = MIN_COUNT;
                state_next = DONE;
              end
`else
              count_next = MIN_COUNT;
              state_next = DONE;
`endif
            end else begin
              count_next = count_reg - ONE;
            end
          end
        end
        DONE: begin
          if (bus.start) begin
            count_next = shadow_reg;
            state_next = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.count = count_reg;
  assign bus.busy  = (state_reg == RUN);
  assign bus.zero  = (count_reg == MIN_COUNT);
  assign bus.tc    = tc_reg;

endmodule

// File: tb/tb_loadable_down_counter_5bit.sv
// Scoreboard bench for loadable_down_counter_5bit: a behavioural timer model queues the
// expected outputs for each clock edge and a monitor compares them after the edge.
module tb_loadable_down_counter_5bit;

  logic clk;
  logic rst;

  loadable_down_counter_5bit_if #(.WIDTH(5)) bus ();

  loadable_down_counter_5bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] count;
    logic       busy;
    logic       zero;
    logic       tc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: a timer phase, the remaining count and the remembered preset.
  localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_DONE = 3;
  int m_phase  = P_IDLE;
  int m_count  = 0;
  int m_shadow = 0;
  bit m_tc     = 0;

  task automatic model_step(input bit r, input bit ld, input int d, input bit st, input bit e);
    bit auto_reload;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    auto_reload = 1'b1;
`else
    auto_reload = 1'b0;
`endif
    m_tc = 0;
    if (r) begin
      m_phase = P_IDLE; m_count = 0; m_shadow = 0;
    end else if (ld) begin
      m_count = d; m_shadow = d;
      if (m_phase != P_RUN) m_phase = P_ARMED;
    end else if (st && m_phase == P_ARMED) begin
      m_phase = P_RUN;
    end else if (st && m_phase == P_DONE) begin
      m_count = m_shadow; m_phase = P_RUN;
    end else if (m_phase == P_RUN) begin
      if (m_count == 0) begin
        m_tc = 1; m_phase = P_DONE;
      end else if (e) begin
        if (m_count == 1) begin
          m_tc = 1;
          if (auto_reload && m_shadow != 0) m_count = m_shadow;
          else begin m_count = 0; m_phase = P_DONE; end
        end else begin
          m_count = m_count - 1;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit ld, input int d, input bit st, input bit e);
    exp_t x;
    @(negedge clk);
    rst = r; bus.load = ld; bus.data_in = d[4:0]; bus.start = st; bus.en = e;
    model_step(r, ld, d, st, e);
    x.count = m_count[4:0];
    x.busy  = (m_phase == P_RUN);
    x.zero  = (m_count == 0);
    x.tc    = m_tc;
    exp_q.push_back(x);
  endtask

  // Monitor: compares one queued expectation per clock edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (bus.count === x.count && bus.busy === x.busy &&
            bus.zero === x.zero && bus.tc === x.tc) begin
          passes++;
          $display("chk %0d t=%0t count=%0d busy=%0b zero=%0b tc=%0b", checks, $time,
                   bus.count, bus.busy, bus.zero, bus.tc);
        end else begin
          $display("FAIL edge_check %0d t=%0t got count=%0d busy=%0b zero=%0b tc=%0b exp count=%0d busy=%0b zero=%0b tc=%0b",
                   checks, $time, bus.count, bus.busy, bus.zero, bus.tc,
                   x.count, x.busy, x.zero, x.tc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; bus.load = 1'b0; bus.data_in = '0; bus.start = 1'b0; bus.en = 1'b0;

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 1);

    // load 5, start, en held high
    cycle(0, 1, 5, 0, 1);
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 1);

    // load 4, start, en toggling; then retrigger from DONE
    cycle(0, 1, 4, 0, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, (i % 2) == 0);
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1);

    // zero preset: no underflow
    cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

    // load and start together from IDLE, then reload during RUN at count 5
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 7, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 3, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);

    // periodic behaviour (one-shot unless auto reload is built in)
    cycle(0, 1, 3, 0, 1);
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1);

    // asynchronous reset mid-clock while running at count 9
    cycle(0, 1, 9, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.count === 5'd0 && bus.busy === 1'b0 && bus.zero === 1'b1 && bus.tc === 1'b0) begin
      passes++;
      $display("chk %0d async reset count=%0d busy=%0b zero=%0b tc=%0b", checks,
               bus.count, bus.busy, bus.zero, bus.tc);
    end else begin
      $display("FAIL async_reset got count=%0d busy=%0b zero=%0b tc=%0b exp count=0 busy=0 zero=1 tc=0",
               bus.count, bus.busy, bus.zero, bus.tc);
    end
    cycle(1, 0, 0, 0, 0);

    // randomized traffic with short presets so terminals occur often
    for (int i = 0; i < 350; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 12)),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) < 7));
    end

    @(posedge clk);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL queue_drain got %0d pending exp 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
